// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback arbiter: destination/data request record and
// the write-port source select.
package wb_pkg;

  localparam int unsigned WB_DEPTH   = 32;
  localparam int unsigned WB_BITS    = 64;
  localparam int unsigned REG_ADDR_W = $clog2(WB_DEPTH);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_BITS-1:0]    data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_FIFO,
    SRC_BYPASS
  } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-result FIFO. Occupancy is tracked by an explicit counter so full and empty never depend
// on pointer equality; per-entry valid/rd is exported for the pending-write mask.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  push,
  input  wb_req_t                               push_req,
  input  logic                                  pop,
  output wb_req_t                               head,
  output logic [$clog2(QDEPTH):0]               count,
  output logic [QDEPTH-1:0]                     ent_valid,
  output logic [QDEPTH-1:0][REG_ADDR_W-1:0]     ent_rd
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  wb_req_t         mem_q [QDEPTH];
  logic [PW-1:0]   rd_q;
  logic [PW-1:0]   wr_q;
  logic [CW-1:0]   count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_req;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;

  // An entry is live when its distance past the read pointer (mod QDEPTH) is below occupancy.
  always_comb begin
    logic [PW-1:0] off;
    off       = '0;
    ent_valid = '0;
    ent_rd    = '0;
    for (int i = 0; i < int'(QDEPTH); i++) begin
      off          = PW'(i) - rd_q;
      ent_valid[i] = ({1'b0, off} < count_q);
      ent_rd[i]    = mem_q[i].rd;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Drives the register file's single write port from single-cycle ALU results and buffered
// variable-latency load results; exports a mask of registers with queued load writes.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH  = WB_DEPTH,
  parameter int unsigned BITS   = WB_BITS,
  parameter int unsigned QDEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_valid,
  input  logic [$clog2(DEPTH)-1:0]   alu_rd,
  input  logic [BITS-1:0]            alu_data,
  output logic                       alu_ready,
  input  logic                       mem_valid,
  input  logic [$clog2(DEPTH)-1:0]   mem_rd,
  input  logic [BITS-1:0]            mem_data,
  output logic                       mem_ready,
  output logic                       wb_en,
  output logic [$clog2(DEPTH)-1:0]   wb_addr,
  output logic [BITS-1:0]            wb_data,
  output logic [DEPTH-1:0]           pend_mask,
  output logic [$clog2(QDEPTH):0]    q_count
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  logic                                full;
  logic                                empty;
  logic                                alu_wr;
  logic                                mem_wr;
  logic                                push;
  logic                                pop;
  wb_src_t                             src;
  wb_req_t                             alu_req;
  wb_req_t                             mem_req;
  wb_req_t                             head;
  wb_req_t                             wb_d;
  wb_req_t                             wb_q;
  logic                                wb_en_d;
  logic                                wb_en_q;
  logic [QDEPTH-1:0]                   ent_valid;
  logic [QDEPTH-1:0][REG_ADDR_W-1:0]   ent_rd;

  assign full  = (q_count == CW'(QDEPTH));
  assign empty = (q_count == '0);

  assign alu_ready = !full;
  assign mem_ready = !full;

  // Writes to x0 complete the handshake but never compete for the port or enter the FIFO.
  assign alu_wr = alu_valid && alu_ready && (alu_rd != '0);
  assign mem_wr = mem_valid && mem_ready && (mem_rd != '0);

  assign alu_req = '{rd: alu_rd, data: alu_data};
  assign mem_req = '{rd: mem_rd, data: mem_data};

  always_comb begin
    src = SRC_NONE;
    if (full) begin
      src = SRC_FIFO;
    end else if (alu_wr) begin
      src = SRC_ALU;
    end else if (!empty) begin
      src = SRC_FIFO;
    end else if (mem_wr) begin
      src = SRC_BYPASS;
    end
  end

  assign pop  = (src == SRC_FIFO);
  assign push = mem_wr && (src != SRC_BYPASS);

  wb_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_req  (mem_req),
    .pop       (pop),
    .head      (head),
    .count     (q_count),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );

  always_comb begin
    wb_d    = wb_q;
    wb_en_d = 1'b1;
    unique case (src)
      SRC_ALU:    wb_d = alu_req;
      SRC_FIFO:   wb_d = head;
      SRC_BYPASS: wb_d = mem_req;
      default:    wb_en_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en_q <= 1'b0;
      wb_q    <= '0;
    end else begin
      wb_en_q <= wb_en_d;
      wb_q    <= wb_d;
    end
  end

  assign wb_en   = wb_en_q;
  assign wb_addr = wb_q.rd;
  assign wb_data = wb_q.data;

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < int'(QDEPTH); i++) begin
      if (ent_valid[i]) begin
        pend_mask[ent_rd[i]] = 1'b1;
      end
    end
    pend_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: immediate assertions on key outputs plus a two-queue
// scoreboard (ALU results, load results) matched against every register-file write.
module tb_writeback_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [63:0] mem_data;
  logic        mem_ready;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic [31:0] pend_mask;
  logic [2:0]  q_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [68:0] alu_exp [$];
  logic [68:0] mem_exp [$];
  logic [68:0] mon_got;
  logic        mon_ok;
  logic        a_acc;
  logic        m_acc;
  int          a_i;
  int          m_i;

  writeback_arbiter #(
    .DEPTH  (32),
    .BITS   (64),
    .QDEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .pend_mask (pend_mask),
    .q_count   (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus; the handshake outcome is recorded before the rising edge.
  task automatic step(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                      input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                      output logic aa, output logic ma);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
    #1;
    aa = av && alu_ready;
    ma = mv && mem_ready;
    if (aa && ard != 5'd0) alu_exp.push_back({ard, ad});
    if (ma && mrd != 5'd0) mem_exp.push_back({mrd, md});
    @(negedge clk);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    alu_rd    = '0;
    mem_rd    = '0;
    alu_data  = '0;
    mem_data  = '0;
  endtask

  task automatic idle();
    logic aa, ma;
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, aa, ma);
  endtask

  // Every write must be the oldest outstanding result of one of the two sources.
  always @(negedge clk) begin
    if (rst_n && wb_en) begin
      mon_got = {wb_addr, wb_data};
      mon_ok  = 1'b0;
      if (alu_exp.size() > 0 && alu_exp[0] == mon_got) begin
        void'(alu_exp.pop_front());
        mon_ok = 1'b1;
      end else if (mem_exp.size() > 0 && mem_exp[0] == mon_got) begin
        void'(mem_exp.pop_front());
        mon_ok = 1'b1;
      end
      n_checks++;
      assert (mon_ok === 1'b1)
      else begin
        n_fail++;
        $error("FAIL wb_write: observed rd=%0d data=%0h, expected alu head %0h or load head %0h",
               wb_addr, wb_data, (alu_exp.size() > 0) ? alu_exp[0] : 69'd0,
               (mem_exp.size() > 0) ? mem_exp[0] : 69'd0);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    mem_valid = 1'b0;
    mem_rd    = '0;
    mem_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_wb_en", 64'(wb_en), 64'd0);
    check("rst_wb_addr", 64'(wb_addr), 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_q_count", 64'(q_count), 64'd0);
    check("rst_pend_mask", 64'(pend_mask), 64'd0);
    rst_n = 1'b1;
    idle();

    // ALU only
    step(1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 5'd0, 64'd0, a_acc, m_acc);
    check("alu_wb_en", 64'(wb_en), 64'd1);
    check("alu_wb_addr", 64'(wb_addr), 64'd5);
    check("alu_wb_data", wb_data, 64'hDEAD_BEEF);
    idle();
    check("alu_idle_wb_en", 64'(wb_en), 64'd0);
    check("alu_idle_hold_addr", 64'(wb_addr), 64'd5);

    // Load bypass
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h1234, a_acc, m_acc);
    check("byp_wb_en", 64'(wb_en), 64'd1);
    check("byp_wb_addr", 64'(wb_addr), 64'd7);
    check("byp_q_count", 64'(q_count), 64'd0);
    check("byp_pend_mask", 64'(pend_mask), 64'd0);
    idle();

    // Conflict: ALU commits first, load waits one cycle in the FIFO
    step(1'b1, 5'd3, 64'd1, 1'b1, 5'd4, 64'd2, a_acc, m_acc);
    check("cfl_n1_addr", 64'(wb_addr), 64'd3);
    check("cfl_n1_q_count", 64'(q_count), 64'd1);
    check("cfl_n1_pend_mask", 64'(pend_mask), 64'h10);
    idle();
    check("cfl_n2_wb_en", 64'(wb_en), 64'd1);
    check("cfl_n2_addr", 64'(wb_addr), 64'd4);
    check("cfl_n2_data", wb_data, 64'd2);
    check("cfl_n2_q_count", 64'(q_count), 64'd0);
    idle();

    // x0 results are accepted and dropped
    check("x0_alu_ready", 64'(alu_ready), 64'd1);
    check("x0_mem_ready", 64'(mem_ready), 64'd1);
    step(1'b1, 5'd0, 64'hFF, 1'b1, 5'd0, 64'h55, a_acc, m_acc);
    check("x0_alu_acc", 64'(a_acc), 64'd1);
    check("x0_mem_acc", 64'(m_acc), 64'd1);
    check("x0_wb_en", 64'(wb_en), 64'd0);
    check("x0_q_count", 64'(q_count), 64'd0);
    check("x0_pend0", 64'(pend_mask[0]), 64'd0);
    idle();
    check("x0_after_wb_en", 64'(wb_en), 64'd0);

    // Full FIFO: both sources valid every cycle, load rds cycle 8..11
    a_i = 0;
    m_i = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      step(1'b1, 5'(16 + a_i % 8), 64'hA000 + 64'(a_i),
           1'b1, 5'(8 + m_i % 4), 64'hB000 + 64'(m_i), a_acc, m_acc);
      if (a_acc) a_i++;
      if (m_acc) m_i++;
      if (cyc == 3) begin
        check("full_q_count", 64'(q_count), 64'd4);
        check("full_mem_ready", 64'(mem_ready), 64'd0);
        check("full_alu_ready", 64'(alu_ready), 64'd0);
        check("full_pend_mask", 64'(pend_mask), 64'h0F00);
      end
      if (cyc == 4) begin
        check("full_head_wb_en", 64'(wb_en), 64'd1);
        check("full_head_addr", 64'(wb_addr), 64'd8);
        check("full_head_data", wb_data, 64'hB000);
      end
    end
    for (int k = 0; k < 20 && q_count != 0; k++) idle();
    check("drain_q_count", 64'(q_count), 64'd0);
    idle();
    check("drain_alu_left", 64'(alu_exp.size()), 64'd0);
    check("drain_load_left", 64'(mem_exp.size()), 64'd0);
    check("stream_alu_accepts", 64'(a_i > 5), 64'd1);
    check("stream_load_accepts", 64'(m_i > 5), 64'd1);

    // Reset mid-stream with three loads queued behind ALU traffic
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 5'(20 + k), 64'hC000 + 64'(k), 1'b1, 5'(12 + k), 64'hD000 + 64'(k),
           a_acc, m_acc);
    end
    check("mid_q_count_before", 64'(q_count), 64'd3);
    check("mid_pend_before", 64'(pend_mask), 64'h7000);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_wb_en", 64'(wb_en), 64'd0);
    check("mid_q_count", 64'(q_count), 64'd0);
    check("mid_pend_mask", 64'(pend_mask), 64'd0);
    mem_exp.delete();
    alu_exp.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idle();
      check("post_rst_wb_en", 64'(wb_en), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Sits directly upstream of the register file and drives its single write port (addressw, writeData, writeEn).
- Merges two result sources onto that one port:
  - single-cycle ALU results;
  - variable-latency load results from the memory unit.
- Load results are buffered in a small FIFO so neither source loses data.
- Exports a pending-write mask so the issue stage can stall on registers with queued writes.

Parameters:
- DEPTH, 32, number of architectural registers (register file depth).
- BITS, 64, data width (register file width).
- QDEPTH, 4, load-result FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result valid
- alu_rd  in  $clog2(DEPTH)  ALU destination register
- alu_data  in  BITS  ALU result
- alu_ready  out  1  ALU result accepted this cycle
- mem_valid  in  1  load result valid
- mem_rd  in  $clog2(DEPTH)  load destination register
- mem_data  in  BITS  load result
- mem_ready  out  1  load result accepted this cycle
- wb_en  out  1  to register file writeEn
- wb_addr  out  $clog2(DEPTH)  to register file addressw
- wb_data  out  BITS  to register file writeData
- pend_mask  out  DEPTH  bit r set = a write to register r is queued in the FIFO
- q_count  out  $clog2(QDEPTH)+1  FIFO occupancy

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- Reset values: wb_en=0, wb_addr=0, wb_data=0, FIFO empty, q_count=0, pend_mask=0.
- Handshake: a transfer occurs when valid&&ready in the same cycle. Inputs are sampled at the rising edge.
- alu_ready and mem_ready are combinational from registered state only, never from the valid inputs.
- mem_ready = (q_count < QDEPTH).
- alu_ready = (q_count < QDEPTH).
  - When the FIFO is full, ALU is held off for one cycle so the FIFO drains. This gives starvation freedom.
- Write-port selection, once per cycle, in priority order:
  1. FIFO full: dequeue FIFO head to the write port.
  2. ALU transfer: ALU result to the write port.
  3. FIFO non-empty: dequeue FIFO head.
  4. FIFO empty and load transfer this cycle: bypass the load result straight to the write port without enqueueing.
  5. Otherwise wb_en=0 on the next cycle. wb_addr and wb_data hold their last values.
- Load accepted but not sent to the write port this cycle: enqueue it.
  - Enqueue and dequeue may happen in the same cycle.
  - q_count changes by (enq - deq).
- Outputs wb_en, wb_addr and wb_data are registered.
  - ALU latency is 1 cycle: accept at edge N, wb_en=1 after edge N.
  - Load latency is 1 cycle via bypass. Otherwise it is 1 cycle after reaching the FIFO head and winning arbitration.
- x0: any result with rd=0 is accepted and handshaken normally, then discarded.
  - Never enqueued, never raises wb_en.
  - Never sets pend_mask[0], so pend_mask[0] is constantly 0.
- Ordering:
  - Load results leave in arrival order (FIFO).
  - When ALU and load transfer in the same cycle, the ALU write commits first.
  - Same-rd ordering across the two sources is the issue stage's responsibility, enforced via pend_mask.
- pend_mask is combinational OR over the valid FIFO entries' one-hot rd. It excludes the entry dequeued in the current cycle only after the edge.
- FIFO pointers: wrap modulo QDEPTH. Full/empty are distinguished by q_count, not pointer equality.
- Reset asserted mid-operation:
  - FIFO contents and pend_mask are cleared immediately (asynchronous).
  - wb_en drops immediately.
  - Results in flight upstream are lost; upstream is reset by the same rst_n.

Decomposition:
- Package wb_pkg holds:
  - the localparam REG_ADDR_W = $clog2(DEPTH);
  - the packed struct typedef wb_req_t {rd, data};
  - an enum wb_src_t {SRC_NONE, SRC_ALU, SRC_FIFO, SRC_BYPASS} used for the arbitration select.
- One sub-module, wb_fifo:
  - parameterised QDEPTH, holds wb_req_t entries;
  - exposes push/pop, head, count, and the per-entry valid/rd vector used for pend_mask.

Test Plan:
- Reset mid-stream: 3 loads queued, assert rst_n=0 -> wb_en=0, q_count=0, pend_mask=0 within the same cycle, no write after release.
- ALU only: alu_valid, rd=5, data=64'hDEAD_BEEF at edge N -> after edge N wb_en=1, wb_addr=5, wb_data=64'hDEAD_BEEF; then wb_en=0 when idle.
- Load bypass: FIFO empty, no ALU, mem rd=7, data=64'h1234 -> next cycle wb_en=1, wb_addr=7, q_count stays 0, pend_mask stays 0.
- Conflict: same cycle ALU rd=3 data=1 and mem rd=4 data=2 ->
  - cycle N+1: write rd=3;
  - q_count=1 and pend_mask=1<<4 during N+1;
  - cycle N+2: write rd=4;
  - q_count=0.
- Full FIFO: ALU and mem valid every cycle, mem rds 8..11 ->
  - q_count reaches 4;
  - mem_ready=0 and alu_ready=0;
  - next write is FIFO head rd=8;
  - no result dropped or duplicated over 20 cycles (scoreboard check).
- x0: ALU rd=0 data=64'hFF and mem rd=0 -> both handshakes complete, wb_en stays 0, q_count=0, pend_mask[0]=0.
